r_vector_writer: RTL
====================

Name: r_vector_writer

Overview:
Write-side counterpart of the m-element read path. Accepts result elements from the compute datapath over a valid/ready handshake, buffers one element, and writes it into the 1024x16 vector memory when the memory arbiter grants a write. Addresses follow the same interleave as the read side: layer, then minor quadrant, then major quadrant, with 8 elements per filter group. One frame is 512 elements, started by `start`; `done` is raised when the frame completes.

Parameters:
- ROW_BASE, 6'd4, row offset of element 0 in every group.
- ROW_STRIDE, 6'd4, row increment between consecutive elements of a group.
- GROUP_LEN, 8, elements per filter group; fixed at 8, since the index is 3 bits.

Ports:
- clock  in  1  single clock, rising edge.
- clear  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame; honoured only in IDLE or DONE.
- r_element_valid  in  1  producer has an element.
- r_element  in  16  element data.
- r_element_ready  out  1  writer accepts the element this cycle (combinational).
- write_grant  in  1  arbiter permits a memory write this cycle.
- vector_memory_address  out  10  registered write address {row[5:0], col[3:0]}.
- vector_write_data  out  16  registered write data.
- memory_write_enable  out  1  registered write strobe.
- last_element  out  1  registered; high with the write strobe for element 7 of a group.
- done  out  1  registered; high from frame completion until the next start or clear.

Behaviour:
- States:
  - IDLE: reset state.
  - RUN.
  - DONE.
- Transitions:
  - IDLE --start--> RUN.
  - RUN --512th write fired--> DONE.
  - DONE --start--> RUN.
  - start while in RUN is ignored.
- On entry to RUN:
  - group index, layer, minor and major counters clear to 0.
  - hold register empties.
- Hold register:
  - One entry.
  - hold_valid is set on accept and cleared on fire, unless a new accept happens in the same cycle.
- Accept and ready:
  - r_element_ready = (state==RUN) && (!hold_valid || write_grant) && !frame_full.
  - frame_full is high once 512 elements have been accepted.
  - Accept = valid && ready; data is captured into the hold register.
- Fire:
  - Fire = hold_valid && write_grant.
  - The cycle after a fire: memory_write_enable=1, and vector_write_data and vector_memory_address are taken from the hold register and the current counters.
  - On fire, the counters advance.
- Latency:
  - Accept at cycle N → hold valid at N+1.
  - If write_grant is high at N+1, the write strobe is seen at N+2.
  - Sustained throughput is 1 element/cycle with the grant held high.
- Address:
  - row = ROW_BASE + layer + ROW_STRIDE*k, where k = group index 0..7; range 4..35; 6-bit, no overflow.
  - col = {major[1], minor[1], major[0], minor[0]}.
- Counter chain (all 2-bit except k):
  - k (3-bit) increments on every fire.
  - layer increments when k wraps 7→0.
  - minor increments when layer wraps 3→0.
  - major increments when minor wraps 3→0.
- last_element = (k==7) during the fire, registered alongside the strobe.
- Grant low: hold is retained, ready drops if the hold is full, and there is no strobe; data must be unchanged when the grant returns.
- Frame end:
  - The 512th fire moves the state to DONE; done=1 the next cycle.
  - No further accepts; ready=0 in IDLE and DONE.
- Reset values (clear, including mid-frame):
  - state=IDLE, hold empty, counters 0.
  - memory_write_enable=0, last_element=0, done=0.
  - vector_memory_address=0, vector_write_data=0.
  - An in-flight element is discarded.
- Simultaneous accept and fire: the hold is replaced with the new element, and the old element is written.
- Outside fire cycles, memory_write_enable=0; address and data hold their last values.

Decomposition:
- Shared package: ROW_BASE, ROW_STRIDE, GROUP_LEN, FRAME_LEN=512, and the state encoding (IDLE, RUN, DONE), so the read-side manager and this writer agree on the interleave.
- One sub-module: vector_address_sequencer.
  - Inputs: clock, clear, restart, advance.
  - Outputs: row[5:0], col[3:0], last_in_group, last_in_frame.
  - It is reusable by the read path.

Test Plan:
1. clear, then start, then valid with r_element=16'hA001 and write_grant=1 → ready=1; two cycles later we=1, address=10'h040, data=16'hA001, last_element=0.
2. Stream 8 elements with the grant held high → addresses 0x040, 0x080 … 0x200; last_element=1 only on 0x200; element 9 goes to 0x050.
3. Stream 129 elements → element 33 at 0x041 (minor=1), element 129 at 0x042 (major=1).
4. Full frame of 512 elements with random grant gaps → exactly 512 strobes with no gaps or duplicates; final address 0x23F; done=1 the cycle after; ready=0 afterwards.
5. Hold the grant low for 5 cycles with the hold full → ready=0 and no strobe; the buffered data is written intact once the grant returns; start pulsed mid-RUN has no effect.
6. Assert clear after 100 writes → next cycle all outputs are 0 and state is IDLE; start again → first write at 0x040.

Source files
------------

// File: rtl/r_vector_writer_pkg.sv
// Shared interleave constants and state encoding for the vector
// memory read and write paths.
package r_vector_writer_pkg;

  localparam logic [5:0]  ROW_BASE   = 6'd4;
  localparam logic [5:0]  ROW_STRIDE = 6'd4;
  localparam int          GROUP_LEN  = 8;
  localparam logic [10:0] FRAME_LEN  = 11'd512;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } wr_state_e;

  function automatic logic [5:0] row_of(
    input logic [1:0] layer,
    input logic [2:0] k
  );
    return ROW_BASE + 6'(layer) + ROW_STRIDE * 6'(k);
  endfunction

endpackage

// File: rtl/vector_address_sequencer.sv
// Walks the filter-group interleave: k, then layer, then minor
// quadrant, then major quadrant.
module vector_address_sequencer
  import r_vector_writer_pkg::*;
(
  input  logic       clock,
  input  logic       clear,
  input  logic       restart,
  input  logic       advance,
  output logic [5:0] row,
  output logic [3:0] col,
  output logic       last_in_group,
  output logic       last_in_frame
);

  logic [2:0] k_q;
  logic [1:0] layer_q;
  logic [1:0] minor_q;
  logic [1:0] major_q;
  logic       wrap_k;
  logic       wrap_layer;
  logic       wrap_minor;

  assign wrap_k     = k_q == 3'(GROUP_LEN - 1);
  assign wrap_layer = wrap_k && layer_q == 2'd3;
  assign wrap_minor = wrap_layer && minor_q == 2'd3;

  always_ff @(posedge clock) begin
    if (clear || restart) begin
      k_q     <= '0;
      layer_q <= '0;
      minor_q <= '0;
      major_q <= '0;
    end else if (advance) begin
      k_q <= k_q + 3'd1;
      if (wrap_k)     layer_q <= layer_q + 2'd1;
      if (wrap_layer) minor_q <= minor_q + 2'd1;
      if (wrap_minor) major_q <= major_q + 2'd1;
    end
  end

  assign row = row_of(layer_q, k_q);
  assign col = {major_q[1], minor_q[1], major_q[0], minor_q[0]};
  assign last_in_group = wrap_k;
  assign last_in_frame = wrap_minor && major_q == 2'd3;

endmodule

// File: rtl/r_vector_writer.sv
// Buffers one result element and writes it to vector memory when
// the arbiter grants, following the read-side address interleave.
module r_vector_writer
  import r_vector_writer_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic        r_element_valid,
  input  logic [15:0] r_element,
  output logic        r_element_ready,
  input  logic        write_grant,
  output logic [9:0]  vector_memory_address,
  output logic [15:0] vector_write_data,
  output logic        memory_write_enable,
  output logic        last_element,
  output logic        done
);

  wr_state_e   state_q;
  wr_state_e   state_d;
  logic        restart;
  logic        hold_valid;
  logic [15:0] hold_data;
  logic [10:0] accept_cnt;
  logic        frame_full;
  logic        accept;
  logic        fire;
  logic [5:0]  row;
  logic [3:0]  col;
  logic        last_in_group;
  logic        last_in_frame;

  assign frame_full = accept_cnt == FRAME_LEN;
  assign r_element_ready = (state_q == ST_RUN)
                        && (!hold_valid || write_grant)
                        && !frame_full;
  assign accept = r_element_valid && r_element_ready;
  assign fire   = hold_valid && write_grant;
  assign done   = state_q == ST_DONE;

  always_ff @(posedge clock) begin
    if (clear) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_RUN;
        restart = 1'b1;
      end
      ST_RUN: if (fire && last_in_frame) state_d = ST_DONE;
      ST_DONE: if (start) begin
        state_d = ST_RUN;
        restart = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      hold_valid            <= 1'b0;
      hold_data             <= '0;
      accept_cnt            <= '0;
      memory_write_enable   <= 1'b0;
      last_element          <= 1'b0;
      vector_memory_address <= '0;
      vector_write_data     <= '0;
    end else begin
      memory_write_enable <= fire;
      last_element        <= fire && last_in_group;
      if (fire) begin
        vector_memory_address <= {row, col};
        vector_write_data     <= hold_data;
      end
      if (restart) begin
        hold_valid <= 1'b0;
        accept_cnt <= '0;
      end else if (accept) begin
        hold_valid <= 1'b1;
        hold_data  <= r_element;
        accept_cnt <= accept_cnt + 11'd1;
      end else if (fire) begin
        hold_valid <= 1'b0;
      end
    end
  end

  vector_address_sequencer u_seq (
    .clock         (clock),
    .clear         (clear),
    .restart       (restart),
    .advance       (fire),
    .row           (row),
    .col           (col),
    .last_in_group (last_in_group),
    .last_in_frame (last_in_frame)
  );

endmodule
